// File: rtl/result_bcd.sv
// result_bcd: captures the controller's datapath result on the rising edge of
// `completed` and converts it to packed BCD plus a sign flag using a
// one-bit-per-clock shift-add-3 (double-dabble) engine.
module result_bcd #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3,
   parameter int SIGNED = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  completed,
   input  logic [WIDTH-1:0]      result,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  neg,
   output logic                  busy,
   output logic                  valid,
   output logic                  done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

   state_t                state_q, state_d;
   logic                  completed_q, completed_d;
   logic [WIDTH-1:0]      bin_q, bin_d;
   logic [4*DIGITS-1:0]   dig_q, dig_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  sign_q, sign_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic                  neg_q, neg_d;
   logic                  busy_q, busy_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;

   logic                  start;
   logic                  is_neg;
   logic [WIDTH-1:0]      mag;
   logic [4*DIGITS-1:0]   dig_adj;

   // Start only on an observed low->high of `completed` while idle.
   assign start  = completed & ~completed_q & (state_q == S_IDLE);
   // Two's complement magnitude; the most negative value still fits unsigned.
   assign is_neg = (SIGNED != 0) && result[WIDTH-1];
   assign mag    = is_neg ? (~result + {{(WIDTH-1){1'b0}}, 1'b1}) : result;

   // Double-dabble correction: bump every digit >= 5 by 3 before shifting.
   always_comb begin
      dig_adj = dig_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_q[4*i +: 4] >= 4'd5)
            dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
   end

   // Next-state and next-output logic for the conversion sequencer.
   always_comb begin
      state_d     = state_q;
      completed_d = completed;
      bin_d       = bin_q;
      dig_d       = dig_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      bcd_d       = bcd_q;
      neg_d       = neg_q;
      busy_d      = busy_q;
      valid_d     = valid_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               bin_d   = mag;
               sign_d  = is_neg;
               dig_d   = '0;
               cnt_d   = CW'(WIDTH);
               busy_d  = 1'b1;
               valid_d = 1'b0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            {dig_d, bin_d} = {dig_adj, bin_q} << 1;
            cnt_d          = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
               state_d = S_FINISH;
         end
         S_FINISH: begin
            bcd_d   = dig_q;
            neg_d   = sign_q;
            valid_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset beats a coincident start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         completed_q <= 1'b1;
         bin_q       <= '0;
         dig_q       <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         bcd_q       <= '0;
         neg_q       <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         completed_q <= completed_d;
         bin_q       <= bin_d;
         dig_q       <= dig_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         bcd_q       <= bcd_d;
         neg_q       <= neg_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
      end
   end

   assign bcd   = bcd_q;
   assign neg   = neg_q;
   assign busy  = busy_q;
   assign valid = valid_q;
   assign done  = done_q;

endmodule

// File: tb/tb_result_bcd.sv
// Bench for result_bcd: a signed and an unsigned instance share stimulus; a
// cycle-count model with integer decimal conversion checks every cycle, and
// directed runs pin hand-computed BCD results.
module tb_result_bcd;
   localparam int W = 8;
   localparam int D = 3;

   logic clk = 1'b0;
   logic rst, completed;
   logic [W-1:0] result;
   logic [4*D-1:0] bcd_s, bcd_u;
   logic neg_s, busy_s, valid_s, done_s;
   logic neg_u, busy_u, valid_u, done_u;

   always #5 clk = ~clk;

   result_bcd #(.WIDTH(W), .DIGITS(D), .SIGNED(1)) dut_s (
      .clk(clk), .rst(rst), .completed(completed), .result(result),
      .bcd(bcd_s), .neg(neg_s), .busy(busy_s), .valid(valid_s), .done(done_s));

   result_bcd #(.WIDTH(W), .DIGITS(D), .SIGNED(0)) dut_u (
      .clk(clk), .rst(rst), .completed(completed), .result(result),
      .bcd(bcd_u), .neg(neg_u), .busy(busy_u), .valid(valid_u), .done(done_u));

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [4*D-1:0] to_bcd(input int v);
      logic [4*D-1:0] r;
      int x;
      x = v;
      r = '0;
      for (int d = 0; d < D; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Model: index 0 = signed instance, 1 = unsigned instance.
   logic [4*D-1:0] m_bcd[2], m_pend[2];
   logic m_neg[2], m_sgn[2], m_busy[2], m_valid[2], m_done[2];
   int   m_phase[2];
   logic m_prev;

   initial begin
      m_prev = 1'b1;
      for (int k = 0; k < 2; k++) begin
         m_bcd[k] = '0; m_pend[k] = '0; m_neg[k] = 0; m_sgn[k] = 0;
         m_busy[k] = 0; m_valid[k] = 0; m_done[k] = 0; m_phase[k] = 0;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         m_prev = 1'b1;
         for (int k = 0; k < 2; k++) begin
            m_bcd[k] = '0; m_neg[k] = 0; m_busy[k] = 0;
            m_valid[k] = 0; m_done[k] = 0; m_phase[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_done[k] = 0;
            if (m_phase[k] == 0 && completed && !m_prev) begin
               int mag;
               m_sgn[k]   = (k == 0) && result[W-1];
               mag        = m_sgn[k] ? (256 - int'(result)) : int'(result);
               m_pend[k]  = to_bcd(mag);
               m_phase[k] = 1;
               m_busy[k]  = 1;
               m_valid[k] = 0;
            end else if (m_phase[k] > 0) begin
               m_phase[k]++;
               if (m_phase[k] == W + 2) begin
                  m_phase[k] = 0;
                  m_busy[k]  = 0;
                  m_valid[k] = 1;
                  m_done[k]  = 1;
                  m_bcd[k]   = m_pend[k];
                  m_neg[k]   = m_sgn[k];
               end
            end
         end
         m_prev = completed;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("bcd_s",   32'(bcd_s),   32'(m_bcd[0]));
         check("neg_s",   32'(neg_s),   32'(m_neg[0]));
         check("busy_s",  32'(busy_s),  32'(m_busy[0]));
         check("valid_s", 32'(valid_s), 32'(m_valid[0]));
         check("done_s",  32'(done_s),  32'(m_done[0]));
         check("bcd_u",   32'(bcd_u),   32'(m_bcd[1]));
         check("neg_u",   32'(neg_u),   32'(m_neg[1]));
         check("busy_u",  32'(busy_u),  32'(m_busy[1]));
         check("valid_u", 32'(valid_u), 32'(m_valid[1]));
         check("done_u",  32'(done_u),  32'(m_done[1]));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Start a conversion with `completed` previously sampled low.
   task automatic run_conv(input logic [W-1:0] r, input logic [4*D-1:0] es,
                           input logic ns, input logic [4*D-1:0] eu);
      int nb, nd;
      nb = 0; nd = 0;
      step();
      result = r;
      completed = 1'b1;
      repeat (W + 5) begin
         @(negedge clk);
         nb += int'(busy_s);
         nd += int'(done_s);
      end
      check("run busy cycles", 32'(nb), 32'(W + 1));
      check("run done count",  32'(nd), 32'd1);
      check("run bcd_s",  32'(bcd_s),  32'(es));
      check("run neg_s",  32'(neg_s),  32'(ns));
      check("run valid_s", 32'(valid_s), 32'd1);
      check("run bcd_u",  32'(bcd_u),  32'(eu));
      check("run neg_u",  32'(neg_u),  32'd0);
      step();
      completed = 1'b0;
      step();
   endtask

   initial begin
      int nb, nd;
      rst = 1'b1; completed = 1'b0; result = '0;
      step();
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("reset bcd",   32'(bcd_s),   32'd0);
      check("reset valid", 32'(valid_s), 32'd0);
      check("reset busy",  32'(busy_s),  32'd0);
      check("reset done",  32'(done_s),  32'd0);

      // completed held high across reset release must not start a conversion
      step();
      rst = 1'b1; completed = 1'b1;
      step();
      step();
      rst = 1'b0;
      nb = 0; nd = 0;
      repeat (20) begin
         @(negedge clk);
         nb += int'(busy_s) + int'(busy_u);
         nd += int'(done_s) + int'(done_u);
      end
      check("held busy", 32'(nb), 32'd0);
      check("held done", 32'(nd), 32'd0);
      step();
      completed = 1'b0;
      step();

      run_conv(8'h7B, 12'h123, 1'b1 ^ 1'b1, 12'h123);
      run_conv(8'hF6, 12'h010, 1'b1, 12'h246);
      run_conv(8'h80, 12'h128, 1'b1, 12'h128);
      run_conv(8'hFF, 12'h001, 1'b1, 12'h255);
      run_conv(8'h00, 12'h000, 1'b0, 12'h000);

      // result change and completed re-toggle mid-conversion are ignored
      step();
      result = 8'h2A;
      completed = 1'b1;
      nb = 0; nd = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (i == 2) begin result = 8'h05; completed = 1'b0; end
         if (i == 3) completed = 1'b1;
         @(negedge clk);
         nb += int'(busy_s);
         nd += int'(done_s);
      end
      check("glitch busy cycles", 32'(nb), 32'(W + 1));
      check("glitch done count",  32'(nd), 32'd1);
      check("glitch bcd_s", 32'(bcd_s), 32'h042);
      check("glitch bcd_u", 32'(bcd_u), 32'h042);
      step();
      completed = 1'b0;
      step();

      // reset at E4 aborts the conversion with no done
      step();
      result = 8'h33;
      completed = 1'b1;
      nd = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (i == 3) rst = 1'b1;
         if (i == 4) begin rst = 1'b0; completed = 1'b0; end
         @(negedge clk);
         nd += int'(done_s);
         if (i == 4) begin
            check("abort bcd",   32'(bcd_s),   32'd0);
            check("abort valid", 32'(valid_s), 32'd0);
            check("abort busy",  32'(busy_s),  32'd0);
         end
      end
      check("abort done count", 32'(nd), 32'd0);
      run_conv(8'h09, 12'h009, 1'b0, 12'h009);

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end
endmodule
